calc_sequencer: RTL
===================

Name: calc_sequencer

Overview:
- Instruction sequencer in front of the simple calculator: register file (8 x 8-bit) plus ALU.
- Accepts calculator instructions over a valid/ready handshake and buffers them in a small FIFO.
- Drives the calculator control bus (WEN, RW, RX, RY, DataIn, Sel, Ctrl) one instruction per cycle, with an optional repeat count for accumulate-style loops.
- Captures the ALU Carry and reports per-instruction completion.

Parameters:
- DEPTH, 4, instruction FIFO entries (power of 2, >=2).
- CNT_W, 4, width of the repeat field; an instruction executes In_rep+1 times.

Ports:
- Clk  input  1  clock, rising edge.
- Rst_n  input  1  asynchronous active-low reset.
- In_valid  input  1  instruction offered.
- In_ready  output  1  FIFO can accept; equals !full.
- In_wen  input  1  instruction writes result to RW.
- In_rw  input  3  destination register.
- In_rx  input  3  X source register.
- In_ry  input  3  Y source register.
- In_imm  input  8  immediate, driven on DataIn.
- In_sel  input  1  1: X = register RX; 0: X = immediate.
- In_ctrl  input  4  ALU operation code, passed through untouched.
- In_rep  input  CNT_W  repeat count minus one.
- WEN  output  1  to calculator.
- RW  output  3  to calculator.
- RX  output  3  to calculator.
- RY  output  3  to calculator.
- DataIn  output  8  to calculator.
- Sel  output  1  to calculator.
- Ctrl  output  4  to calculator.
- Carry  input  1  ALU carry from calculator (combinational on the driven bus).
- Carry_flag  output  1  carry captured from the last executed cycle.
- Done  output  1  one-cycle pulse per completed instruction.
- Busy  output  1  high when in EXEC or FIFO non-empty.
- Level  output  clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (async, Rst_n=0): FIFO emptied, state IDLE.
  - All calculator outputs 0; WEN=0.
  - Carry_flag=0, Done=0, Busy=0, Level=0, In_ready=1.
- Push: occurs on a rising edge with In_valid && In_ready. In_ready is low when Level==DEPTH; a push while full is impossible.
- Push and pop on the same edge: both legal when not full; Level unchanged.
- FSM states:
  - IDLE: calculator bus held at 0.
  - EXEC: calculator bus driven from the registered command register.
- IDLE -> EXEC: on the edge where the FIFO is non-empty. Pop head into the command register; rem <= In_rep of that entry.
- EXEC, every edge:
  - Carry_flag <= Carry. The register file write (if WEN) happens on this same edge.
  - If rem != 0: rem <= rem-1; bus unchanged, same instruction re-executes.
  - If rem == 0: Done <= 1 for the next cycle. Then:
    - If FIFO non-empty: pop next instruction into the command register, stay in EXEC (no bubble).
    - Else: go to IDLE, bus to 0.
- Latency: push at edge T into an empty, idle block.
  - Bus valid during cycle T+1..T+2.
  - Register write at edge T+2.
  - Done high during cycle T+2..T+3.
- Throughput: one calculator cycle per edge. Back-to-back read-after-write is correct because the register file writes at the edge and reads combinationally.
- Repeats: the bus is held constant for In_rep+1 cycles, so WEN is high for In_rep+1 consecutive edges.
- In_rep wrap: the maximum value 2^CNT_W-1 gives 2^CNT_W executions; the counter never wraps.
- Busy = (state==EXEC) || (Level!=0).
- Reset asserted mid-EXEC: aborts immediately; the remaining repeats and queued instructions are discarded.

Optional Feature:
- Macro: CALC_SEQ_STALL_EN.
- With the macro: adds input port Stall (1 bit). While Stall=1 in EXEC:
  - WEN forced 0; the other bus signals keep their values.
  - rem, command register, FIFO read pointer and Carry_flag all hold.
  - No Done is issued.
  - Pushes are still accepted.
  - Stall in IDLE also blocks the IDLE->EXEC transition.
- Without the macro: no Stall port; behaviour is as above with stall permanently 0.

Test Plan:
- Reset/idle: assert Rst_n=0 mid-stream, then release -> all outputs 0, In_ready=1, Level=0, Busy=0.
- Single instruction: push {wen=1,rw=3,rx=0,ry=0,imm=8'h5A,sel=0,ctrl=4'h2,rep=0} at edge T -> WEN=1, RW=3, DataIn=8'h5A, Sel=0, Ctrl=4'h2 for exactly one cycle starting after T+1; Done one cycle after T+2.
- Repeat: push {wen=1,rw=1,rx=1,ry=2,sel=1,rep=3} -> WEN high for exactly 4 consecutive cycles, one Done pulse. Carry_flag matches the Carry driven on the 4th cycle (bench forces Carry=1 on cycle 4 only -> Carry_flag=1).
- Back-to-back and full: push 5 instructions continuously with DEPTH=4 -> In_ready drops when Level=4; all 5 execute in order with no idle bus cycle between them; 5 Done pulses.
- Mid-operation reset: reset during the 2nd of 4 repeats with 2 entries queued -> WEN=0 immediately, Level=0, no further Done after release.
- (CALC_SEQ_STALL_EN) Stall=1 for 3 cycles in the middle of rep=1 -> WEN=0 during the stall; exactly 2 write cycles in total; Done delayed by 3 cycles.

Source files
------------

// File: rtl/calc_sequencer_if.sv
// ============================================================================
// calc_sequencer_if
// Instruction handshake and calculator control bus bundle for calc_sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface calc_sequencer_if #(
  parameter int CNT_W = 4
);
  logic             In_valid;
  logic             In_ready;
  logic             In_wen;
  logic [2:0]       In_rw;
  logic [2:0]       In_rx;
  logic [2:0]       In_ry;
  logic [7:0]       In_imm;
  logic             In_sel;
  logic [3:0]       In_ctrl;
  logic [CNT_W-1:0] In_rep;

  logic             WEN;
  logic [2:0]       RW;
  logic [2:0]       RX;
  logic [2:0]       RY;
  logic [7:0]       DataIn;
  logic             Sel;
  logic [3:0]       Ctrl;
  logic             Carry;

  modport master (
    output In_valid, In_wen, In_rw, In_rx, In_ry, In_imm, In_sel, In_ctrl, In_rep,
    input  In_ready,
    input  WEN, RW, RX, RY, DataIn, Sel, Ctrl,
    output Carry
  );

  modport slave (
    input  In_valid, In_wen, In_rw, In_rx, In_ry, In_imm, In_sel, In_ctrl, In_rep,
    output In_ready,
    output WEN, RW, RX, RY, DataIn, Sel, Ctrl,
    input  Carry
  );
endinterface

`default_nettype wire

// File: rtl/calc_sequencer.sv
// ============================================================================
// calc_sequencer
// FIFO-buffered instruction sequencer driving the calculator control bus with
// per-instruction repeat count. Optional stall input: CALC_SEQ_STALL_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module calc_sequencer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
) (
  input  wire logic                   Clk,
  input  wire logic                   Rst_n,
`ifdef CALC_SEQ_STALL_EN
  input  wire logic                   Stall,
`endif
  calc_sequencer_if.slave             bus,
  output logic                        Carry_flag,
  output logic                        Done,
  output logic                        Busy,
  output logic [$clog2(DEPTH):0]      Level
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic       wen;
    logic [2:0] rw;
    logic [2:0] rx;
    logic [2:0] ry;
    logic [7:0] imm;
    logic       sel;
    logic [3:0] ctrl;
  } cmd_t;

  typedef struct packed {
    cmd_t             cmd;
    logic [CNT_W-1:0] rep;
  } instr_t;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_e;

  state_e           state_q;
  instr_t           mem_q [DEPTH];
  logic [AW:0]      wr_q;
  logic [AW:0]      rd_q;
  logic [CNT_W-1:0] rem_q;
  cmd_t             cmd_q;
  logic             carry_q;
  logic             done_q;

  logic             stall;
  logic             empty;
  logic             full;
  logic             push;
  logic             pop;
  instr_t           in_d;
  instr_t           head;

`ifdef CALC_SEQ_STALL_EN
  assign stall = Stall;
`else
  assign stall = 1'b0;
`endif

  assign Level = wr_q - rd_q;
  assign empty = (wr_q == rd_q);
  assign full  = (Level == (AW+1)'(DEPTH));
  assign push  = bus.In_valid && !full;
  assign head  = mem_q[rd_q[AW-1:0]];
  // A pop happens either to leave IDLE or on the final repeat of the current command.
  assign pop   = !empty && !stall && ((state_q == IDLE) || (rem_q == '0));

  assign in_d.cmd.wen  = bus.In_wen;
  assign in_d.cmd.rw   = bus.In_rw;
  assign in_d.cmd.rx   = bus.In_rx;
  assign in_d.cmd.ry   = bus.In_ry;
  assign in_d.cmd.imm  = bus.In_imm;
  assign in_d.cmd.sel  = bus.In_sel;
  assign in_d.cmd.ctrl = bus.In_ctrl;
  assign in_d.rep      = bus.In_rep;

  always_ff @(posedge Clk) begin
    if (push) begin
      mem_q[wr_q[AW-1:0]] <= in_d;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      rem_q   <= '0;
      cmd_q   <= '0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      if (push) wr_q <= wr_q + (AW+1)'(1);
      if (pop)  rd_q <= rd_q + (AW+1)'(1);
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pop) begin
            cmd_q   <= head.cmd;
            rem_q   <= head.rep;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          if (!stall) begin
            carry_q <= bus.Carry;
            if (rem_q != '0) begin
              rem_q <= rem_q - CNT_W'(1);
            end else begin
              done_q <= 1'b1;
              if (pop) begin
                cmd_q <= head.cmd;
                rem_q <= head.rep;
              end else begin
                cmd_q   <= '0;
                state_q <= IDLE;
              end
            end
          end
        end
      endcase
    end
  end

  // cmd_q is cleared whenever the FSM sits in IDLE, so the bus reads 0 there.
  assign bus.WEN      = cmd_q.wen && !stall;
  assign bus.RW       = cmd_q.rw;
  assign bus.RX       = cmd_q.rx;
  assign bus.RY       = cmd_q.ry;
  assign bus.DataIn   = cmd_q.imm;
  assign bus.Sel      = cmd_q.sel;
  assign bus.Ctrl     = cmd_q.ctrl;
  assign bus.In_ready = !full;

  assign Carry_flag = carry_q;
  assign Done       = done_q;
  assign Busy       = (state_q == EXEC) || !empty;

endmodule

`default_nettype wire
